aoc_range_parser: RTL and testbench

- Upstream stage of the fresh-ID checker. Consumes the raw puzzle input as an ASCII byte stream.
- The input has two sections:
  - range lines "low-high\n";
  - a blank line;
  - ID lines "id\n".
- Emits parsed ranges toward the range FIFO write side and parsed IDs toward the check_addr path, with backpressure on both.
- Runs on the single fast clock. Any CDC into the range FIFO is handled by the FIFO itself.

---
 rtl/aoc_range_parser.sv | 279 +++++++++++++++++++++++++++
 tb/tb_aoc_range_parser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aoc_range_parser.sv
// Byte-stream parser for the fresh-ID puzzle input: "low-high" range lines, a blank line, then ID lines.
// Optional PARSE_STATS_EN adds saturating range/id/line counters.
module aoc_range_parser #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              range_valid,
  input  logic              range_ready,
  output logic [ADDR_W-1:0] range_low,
  output logic [ADDR_W-1:0] range_high,
  output logic              range_fresh,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_addr,
  output logic              done,
  output logic              err
`ifdef PARSE_STATS_EN
  ,
  output logic [15:0]       range_count,
  output logic [15:0]       id_count,
  output logic [15:0]       line_count
`endif
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_IDS  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   acc_r;
  logic                digit_seen_r;
  logic [ADDR_W-1:0]   low_r;
  logic                range_valid_r;
  logic [ADDR_W-1:0]   range_low_r;
  logic [ADDR_W-1:0]   range_high_r;
  logic                id_valid_r;
  logic [ADDR_W-1:0]   id_addr_r;
  logic                done_r;
  logic                err_r;

  logic                in_ready_s;
  logic                accept_s;
  logic                is_digit_s;
  logic                is_nl_s;
  logic                is_cr_s;
  logic                is_dash_s;
  logic [ADDR_W+3:0]   mul_s;
  logic                ovf_s;
  logic [ADDR_W-1:0]   acc_dig_s;
  logic [ADDR_W-1:0]   val_s;
  logic                flush_s;
  logic                acc_load_s;
  logic                clr_s;
  logic                low_load_s;
  logic                emit_range_s;
  logic                emit_id_s;
  logic                err_set_s;
  logic                range_valid_n_s;
  logic                id_valid_n_s;
  logic                done_set_s;

  // A stalled output word blocks input so no second word can overwrite it.
  assign in_ready_s = (state_r != S_DONE) && !done_r &&
                      !(range_valid_r && !range_ready) && !(id_valid_r && !id_ready);
  assign accept_s   = in_valid && in_ready_s;

  assign is_digit_s = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign is_nl_s    = (in_byte == 8'h0A);
  assign is_cr_s    = (in_byte == 8'h0D);
  assign is_dash_s  = (in_byte == 8'h2D);

  // acc*10 + digit as (acc<<3)+(acc<<1)+digit, widened by 4 bits to expose overflow.
  assign mul_s     = ({4'b0000, acc_r} << 3) + ({4'b0000, acc_r} << 1) +
                     {{ADDR_W{1'b0}}, in_byte[3:0]};
  assign ovf_s     = |mul_s[ADDR_W+3:ADDR_W];
  assign acc_dig_s = ovf_s ? {ADDR_W{1'b1}} : mul_s[ADDR_W-1:0];
  assign val_s     = is_digit_s ? acc_dig_s : acc_r;
  assign flush_s   = in_last && (is_digit_s || (is_cr_s && digit_seen_r));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_LOW;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    if (!accept_s) begin
      state_s = state_r;
    end else if (in_last) begin
      state_s = S_DONE;
    end else begin
      case (state_r)
        S_LOW: begin
          if (is_dash_s && digit_seen_r) begin
            state_s = S_HIGH;
          end else if (is_nl_s && !digit_seen_r) begin
            state_s = S_IDS;
          end else begin
            state_s = S_LOW;
          end
        end
        S_HIGH: begin
          if (is_digit_s || is_cr_s) begin
            state_s = S_HIGH;
          end else begin
            state_s = S_LOW;
          end
        end
        S_IDS:   state_s = S_IDS;
        S_DONE:  state_s = S_DONE;
        default: state_s = S_LOW;
      endcase
    end
  end

  // Datapath control decode for the accepted byte.
  always_comb begin
    acc_load_s   = 1'b0;
    clr_s        = 1'b0;
    low_load_s   = 1'b0;
    emit_range_s = 1'b0;
    emit_id_s    = 1'b0;
    err_set_s    = 1'b0;
    if (!accept_s || is_cr_s) begin
      err_set_s = 1'b0;
    end else if (is_digit_s) begin
      acc_load_s = 1'b1;
      err_set_s  = ovf_s;
    end else begin
      case (state_r)
        S_LOW: begin
          if (is_dash_s && digit_seen_r) begin
            low_load_s = 1'b1;
            clr_s      = 1'b1;
          end else if (is_nl_s && !digit_seen_r) begin
            clr_s = 1'b0;
          end else begin
            err_set_s = 1'b1;
            clr_s     = 1'b1;
          end
        end
        S_HIGH: begin
          clr_s = 1'b1;
          if (is_nl_s && digit_seen_r) begin
            emit_range_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end
        S_IDS: begin
          clr_s = 1'b1;
          if (is_nl_s) begin
            emit_id_s = digit_seen_r;
          end else begin
            err_set_s = 1'b1;
          end
        end
        default: clr_s = 1'b0;
      endcase
    end
    // in_last with a number still open behaves as if a '\n' followed.
    if (accept_s && flush_s) begin
      clr_s = 1'b1;
      case (state_r)
        S_LOW:   err_set_s    = 1'b1;
        S_HIGH:  emit_range_s = 1'b1;
        S_IDS:   emit_id_s    = 1'b1;
        default: clr_s        = 1'b1;
      endcase
    end else begin
      clr_s = clr_s;
    end
  end

  assign range_valid_n_s = emit_range_s || (range_valid_r && !range_ready);
  assign id_valid_n_s    = emit_id_s || (id_valid_r && !id_ready);
  assign done_set_s      = (state_s == S_DONE) && !range_valid_n_s && !id_valid_n_s;

  // Accumulator, low bound, output words and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r         <= {ADDR_W{1'b0}};
      digit_seen_r  <= 1'b0;
      low_r         <= {ADDR_W{1'b0}};
      range_valid_r <= 1'b0;
      range_low_r   <= {ADDR_W{1'b0}};
      range_high_r  <= {ADDR_W{1'b0}};
      id_valid_r    <= 1'b0;
      id_addr_r     <= {ADDR_W{1'b0}};
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      if (clr_s) begin
        acc_r        <= {ADDR_W{1'b0}};
        digit_seen_r <= 1'b0;
      end else if (acc_load_s) begin
        acc_r        <= acc_dig_s;
        digit_seen_r <= 1'b1;
      end
      if (low_load_s) begin
        low_r <= acc_r;
      end
      if (emit_range_s) begin
        range_valid_r <= 1'b1;
        if (val_s < low_r) begin
          range_low_r  <= val_s;
          range_high_r <= low_r;
        end else begin
          range_low_r  <= low_r;
          range_high_r <= val_s;
        end
      end else if (range_ready) begin
        range_valid_r <= 1'b0;
      end
      if (emit_id_s) begin
        id_valid_r <= 1'b1;
        id_addr_r  <= val_s;
      end else if (id_ready) begin
        id_valid_r <= 1'b0;
      end
      err_r  <= err_r | err_set_s;
      done_r <= done_r | done_set_s;
    end
  end

`ifdef PARSE_STATS_EN
  logic [15:0] range_count_r;
  logic [15:0] id_count_r;
  logic [15:0] line_count_r;

  // Saturating handoff and line counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_count_r <= 16'd0;
      id_count_r    <= 16'd0;
      line_count_r  <= 16'd0;
    end else begin
      if (range_valid_r && range_ready && (range_count_r != 16'hFFFF)) begin
        range_count_r <= range_count_r + 16'd1;
      end
      if (id_valid_r && id_ready && (id_count_r != 16'hFFFF)) begin
        id_count_r <= id_count_r + 16'd1;
      end
      if (accept_s && is_nl_s && (line_count_r != 16'hFFFF)) begin
        line_count_r <= line_count_r + 16'd1;
      end
    end
  end

  assign range_count = range_count_r;
  assign id_count    = id_count_r;
  assign line_count  = line_count_r;
`endif

  assign in_ready    = in_ready_s;
  assign range_valid = range_valid_r;
  assign range_low   = range_low_r;
  assign range_high  = range_high_r;
  assign range_fresh = range_valid_r;
  assign id_valid    = id_valid_r;
  assign id_addr     = id_addr_r;
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_aoc_range_parser.sv
// Directed bench for aoc_range_parser: ranges, IDs, backpressure, overflow, malformed lines, in_last, reset.
module tb_aoc_range_parser;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_byte = 8'h00;
  logic              in_last = 1'b0;
  logic              range_valid;
  logic              range_ready = 1'b1;
  logic [ADDR_W-1:0] range_low;
  logic [ADDR_W-1:0] range_high;
  logic              range_fresh;
  logic              id_valid;
  logic              id_ready = 1'b1;
  logic [ADDR_W-1:0] id_addr;
  logic              done;
  logic              err;
`ifdef PARSE_STATS_EN
  logic [15:0]       range_count;
  logic [15:0]       id_count;
  logic [15:0]       line_count;
`endif

  int errors = 0;
  int checks = 0;

  aoc_range_parser #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .in_last     (in_last),
    .range_valid (range_valid),
    .range_ready (range_ready),
    .range_low   (range_low),
    .range_high  (range_high),
    .range_fresh (range_fresh),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_addr     (id_addr),
    .done        (done),
    .err         (err)
`ifdef PARSE_STATS_EN
    ,
    .range_count (range_count),
    .id_count    (id_count),
    .line_count  (line_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one byte, wait (bounded) for in_ready, then let one edge accept it.
  task automatic send(input logic [7:0] b, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], 1'b0);
    end
  endtask

  task automatic check_range(input string tag, input int lo, input int hi);
    check({tag, "_valid"}, {31'd0, range_valid}, 32'd1);
    check({tag, "_fresh"}, {31'd0, range_fresh}, 32'd1);
    check({tag, "_low"},   32'(range_low),       32'(lo));
    check({tag, "_high"},  32'(range_high),      32'(hi));
  endtask

  task automatic check_id(input string tag, input int v);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
    check({tag, "_addr"},  32'(id_addr),      32'(v));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready",    {31'd0, in_ready},    32'd1);
    check("rst_range_valid", {31'd0, range_valid}, 32'd0);
    check("rst_id_valid",    {31'd0, id_valid},    32'd0);
    check("rst_done",        {31'd0, done},        32'd0);
    check("rst_err",         {31'd0, err},         32'd0);
    check("rst_range_low",   32'(range_low),       32'd0);
    do_reset();

    // Basic stream with readies high
    send_str("20-24\n");
    check_range("r1", 20, 24);
    send_str("6-8\n");
    check_range("r2", 6, 8);
    send_str("\n");
    check("blank_range_valid", {31'd0, range_valid}, 32'd0);
    check("blank_id_valid",    {31'd0, id_valid},    32'd0);
    send_str("19\n");
    check_id("id19", 19);
    send_str("20\n");
    check_id("id20", 20);
    check("basic_err", {31'd0, err}, 32'd0);

    // Range backpressure
    do_reset();
    range_ready = 1'b0;
    send_str("20-24\n");
    check_range("bp_r1", 20, 24);
    in_valid = 1'b1;
    in_byte  = 8'h36;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_range("bp_hold", 20, 24);
    end
    range_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_drop", {31'd0, range_valid}, 32'd0);
    send_str("-8\n");
    check_range("bp_r2", 6, 8);
    send_str("\n19\n");
    check_id("bp_id19", 19);

    // Swapped bounds
    do_reset();
    send_str("9-3\n");
    check_range("swap", 3, 9);
    send_str("\n");
    check("swap_err", {31'd0, err}, 32'd0);

    // Overflow saturation and exact maximum
    do_reset();
    send_str("\n131072\n");
    check_id("ovf", 131071);
    check("ovf_err", {31'd0, err}, 32'd1);
    do_reset();
    send_str("\n131071\n");
    check_id("max", 131071);
    check("max_err", {31'd0, err}, 32'd0);

    // Malformed line dropped
    do_reset();
    send_str("5-x7\n");
    check("bad_range_valid", {31'd0, range_valid}, 32'd0);
    check("bad_err",         {31'd0, err},         32'd1);
    send_str("1-2\n");
    check_range("after_bad", 1, 2);
    send_str("\n");
    check("after_bad_blank", {31'd0, range_valid}, 32'd0);

    // CRLF endings
    do_reset();
    send_str("20-24\r\n");
    check_range("crlf_r", 20, 24);
    send_str("\r\n7\r\n");
    check_id("crlf_id", 7);
    check("crlf_err", {31'd0, err}, 32'd0);

    // in_last flush and done
    do_reset();
    id_ready = 1'b0;
    send_str("\n2");
    send(8'h36, 1'b1);
    check_id("last_id", 26);
    check("last_done_pre",  {31'd0, done},     32'd0);
    check("last_in_ready",  {31'd0, in_ready}, 32'd0);
    id_ready = 1'b1;
    @(posedge clk);
    #1;
    check("last_id_drop",   {31'd0, id_valid}, 32'd0);
    check("last_done",      {31'd0, done},     32'd1);
    check("last_in_ready2", {31'd0, in_ready}, 32'd0);
    check("last_err",       {31'd0, err},      32'd0);

    // Asynchronous reset mid-line with a stalled range
    do_reset();
    range_ready = 1'b0;
    send_str("1-2\n");
    check_range("pre_rst", 1, 2);
    in_valid = 1'b1;
    in_byte  = 8'h35;
    #2;
    rst = 1'b1;
    #1;
    check("arst_range_valid", {31'd0, range_valid}, 32'd0);
    check("arst_range_low",   32'(range_low),       32'd0);
    check("arst_in_ready",    {31'd0, in_ready},    32'd1);
    check("arst_done",        {31'd0, done},        32'd0);
    in_valid    = 1'b0;
    range_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_str("3-4\n");
    check_range("post_rst", 3, 4);
    check("post_rst_err", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
